kp_start_driver: RTL
====================

# kp_start_driver

Synthesizable ap_ctrl_hs initiator that drives the block-level start handshake of an HLS top (e.g. kp_502_7) for a programmed number of transactions. It is the driving counterpart to the dataflow/module-status monitors: it issues `ap_start`, counts `ap_ready`/`ap_done`, and timestamps each transaction. It reports per-transaction start-to-done latency, min/max latency and total run cycles, then raises `finish` for the monitor and testbench.

## Interface
Parameters:
- `CNT_W`, 32, width of cycle counter, transaction counts and latency values
- `DEPTH`, 4, timestamp FIFO depth, i.e. the maximum number of transactions outstanding (started but not done); power of two, ≥2

Ports:
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `go`  in  1  one-cycle pulse that starts a run; ignored while `busy`
- `num_trans`  in  CNT_W  number of transactions; sampled on an accepted `go`
- `ap_start`  out  1  start request to DUT (registered)
- `ap_continue`  out  1  constant 1 (ap_ctrl_hs)
- `ap_ready`  in  1  DUT ready; handshake completes on `ap_start & ap_ready`
- `ap_done`  in  1  DUT done pulse, one per transaction, in order
- `busy`  out  1  run in progress
- `finish`  out  1  level; set when run completes, cleared by next accepted `go`
- `done_count`  out  CNT_W  transactions completed in current run
- `lat_valid`  out  1  one-cycle pulse with each accepted `ap_done`
- `lat_value`  out  CNT_W  latency of that transaction
- `lat_min` / `lat_max`  out  CNT_W  running extremes for the run
- `total_cycles`  out  CNT_W  cycles from accepted `go` to `finish`
- `err_proto`  out  1  sticky; `ap_done` with no outstanding transaction

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on `go`, load `num_trans` and clear `done_count`, the issued count, the cycle counter, `lat_min` (to all-ones), `lat_max` (to 0), `finish` and the FIFO.
  - If `num_trans` is 0, go to FINISH.
  - Otherwise go to ISSUE.
- ISSUE: `ap_start` is 1 whenever issued < `num_trans` and the FIFO is not full.
  - A new transaction begins on the first cycle `ap_start` is 1 after IDLE or after a completed handshake. The current cycle count is pushed into the FIFO on that cycle.
  - On `ap_start & ap_ready`, issued increments.
  - `ap_start` stays high on the following cycle if more transactions remain and the FIFO is not full; back-to-back starts are allowed.
  - When issued reaches `num_trans`, go to DRAIN.
  - If the FIFO is full, `ap_start` drops until a pop occurs.
- `ap_done` in any non-IDLE state with the FIFO non-empty:
  - Pop the FIFO.
  - `lat_value = cycle_cnt - ts` (modulo 2^CNT_W).
  - Pulse `lat_valid`, increment `done_count`, update min/max.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- `ap_done` with the FIFO empty (including in IDLE): set `err_proto`, no counter changes.
- DRAIN: `ap_start` is 0. When `done_count` reaches `num_trans`, go to FINISH.
- FINISH: latch `total_cycles`, set `finish`, clear `busy`, return to IDLE the next cycle.
- `cycle_cnt` counts every cycle from the accepted `go` until FINISH.

## Timing
- Reset values: `ap_start` 0, `ap_continue` 1, `busy` 0, `finish` 0, `lat_valid` 0, all counters 0, `lat_min` all-ones, `err_proto` 0, FSM in IDLE, FIFO empty.
- Reset mid-run: all of the above take effect on the next edge; outstanding transactions are discarded.
- Accepted `go` at cycle 0 (`num_trans` > 0): `busy` = 1 and `ap_start` = 1 in cycle 1. The cycle-1 timestamp is 1.
- Handshake in cycle k: `ap_start` is 1 in cycle k+1 if another transaction remains and the FIFO is not full; otherwise it is 0.
- `ap_done` in cycle d:
  - `lat_valid`, `lat_value`, `done_count`, min and max update in cycle d+1.
  - The FIFO slot is reusable in cycle d+1.
- Last `ap_done` in cycle d: FINISH in cycle d+1, `finish` = 1 and `busy` = 0 in cycle d+2. `total_cycles` = d+1.
- `num_trans` = 0: `finish` = 1 two cycles after `go`; `ap_start` never asserts.
- `go` while `busy`: ignored.

## Test plan
- Single transaction: `num_trans`=1, DUT answers `ap_ready` and `ap_done` 75 cycles after `ap_start` rises. Expect `ap_start` high exactly until the ready cycle, `lat_value`=75, `lat_min`=`lat_max`=75, `finish` rises, `done_count`=1.
- Sequential run: `num_trans`=5, DUT ready/done at 75-cycle latency, non-pipelined. Expect 5 `lat_valid` pulses of 75, `done_count`=5, `err_proto`=0.
- Pipelined/backpressure: `num_trans`=8, DEPTH=4, `ap_ready` every cycle, `ap_done` delayed 20 cycles. Expect `ap_start` to drop after 4 outstanding, resume the cycle after the first done, and all 8 latencies reported in order.
- Simultaneous push and pop: ready and done in the same cycle. Occupancy unchanged; latencies correct.
- Zero transactions: `num_trans`=0. `finish` = 1 at `go`+2, `ap_start` stays 0, `total_cycles`=1.
- Protocol error and reset: spurious `ap_done` in IDLE sets `err_proto`. Reset asserted mid-DRAIN returns every output to its reset value on the next edge; a following run behaves normally.

Source files
------------

// File: rtl/kp_start_driver.sv
// kp_start_driver
//   Drives the ap_ctrl_hs start handshake of an HLS block for a programmed
//   number of transactions. It timestamps every start, measures the
//   start-to-done latency of each transaction and keeps run statistics.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   go, num_trans     start pulse and transaction count (taken while idle)
//   ap_start          registered start request to the HLS block
//   ap_continue       tied high
//   ap_ready, ap_done handshake inputs from the HLS block
//   busy, finish      run in progress / run complete (level)
//   done_count        transactions completed in this run
//   lat_valid/value   one-cycle latency report per completed transaction
//   lat_min/max       running latency extremes for the run
//   total_cycles      cycles from accepted go to the FINISH state
//   err_proto         sticky: ap_done seen with nothing outstanding
module kp_start_driver #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] num_trans,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] done_count,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_value,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] total_cycles,
  output logic             err_proto
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] ntrans, issued, cycle_cnt;
  logic [CNT_W-1:0] ts_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ, occ_n;
  // pend: the current ap_start request already owns a FIFO slot (its
  // timestamp was pushed) and is waiting for ap_ready.
  logic             pend, pend_n;
  logic             accept, hs, push, pop, spurious, start_n;
  logic [CNT_W-1:0] issued_n, done_n, lat;

  assign ap_continue = 1'b1;

  always_comb begin
    accept   = (state == IDLE) && go;
    hs       = ap_start && ap_ready;
    push     = ap_start && !pend;
    pop      = ap_done && (occ != '0) && (state != IDLE);
    spurious = ap_done && (occ == '0);
    lat      = cycle_cnt - ts_mem[rd_ptr];
    issued_n = issued + CNT_W'(hs);
    done_n   = done_count + CNT_W'(pop);
    occ_n    = occ + (AW+1)'(push) - (AW+1)'(pop);
    pend_n   = (pend || push) && !hs;
    state_n  = state;
    start_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = (num_trans == '0) ? FINISH : ISSUE;
          start_n = (num_trans != '0);
        end
      end
      ISSUE: begin
        if (issued_n == ntrans)
          state_n = (done_n == ntrans) ? FINISH : DRAIN;
        else
          // a request holding a slot stays up; a fresh one needs a free slot
          start_n = pend_n || (occ_n < FULL_OCC);
      end
      DRAIN: begin
        if (done_n == ntrans) state_n = FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ap_start     <= 1'b0;
      busy         <= 1'b0;
      finish       <= 1'b0;
      lat_valid    <= 1'b0;
      lat_value    <= '0;
      done_count   <= '0;
      lat_min      <= '1;
      lat_max      <= '0;
      total_cycles <= '0;
      err_proto    <= 1'b0;
      ntrans       <= '0;
      issued       <= '0;
      cycle_cnt    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      pend         <= 1'b0;
    end else begin
      state     <= state_n;
      ap_start  <= start_n;
      lat_valid <= pop;
      if (spurious) err_proto <= 1'b1;
      if (accept) begin
        ntrans     <= num_trans;
        issued     <= '0;
        done_count <= '0;
        // the go cycle is cycle 0, so the first start cycle reads 1
        cycle_cnt  <= CNT_W'(1);
        lat_min    <= '1;
        lat_max    <= '0;
        finish     <= 1'b0;
        busy       <= 1'b1;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        occ        <= '0;
        pend       <= 1'b0;
      end else begin
        if (state == ISSUE || state == DRAIN) cycle_cnt <= cycle_cnt + CNT_W'(1);
        issued <= issued_n;
        pend   <= pend_n;
        occ    <= occ_n;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr     <= rd_ptr + AW'(1);
          lat_value  <= lat;
          done_count <= done_n;
          if (lat < lat_min) lat_min <= lat;
          if (lat > lat_max) lat_max <= lat;
        end
        if (state == FINISH) begin
          total_cycles <= cycle_cnt;
          finish       <= 1'b1;
          busy         <= 1'b0;
        end
      end
    end
  end

  // timestamp storage, no reset needed: occupancy guards every read
  always_ff @(posedge clock) begin
    if (push) ts_mem[wr_ptr] <= cycle_cnt;
  end

endmodule
